led_pwm_reg_ctrl: RTL and testbench
===================================

# led_pwm_reg_ctrl

Register controller between the SPI slave byte receiver and the LED PWM outputs. It decodes each completed SPI (address, data) frame into a small configuration register bank and runs a three-channel 8-bit PWM generator with a prescaler. Duty-cycle changes are double-buffered and committed only at a PWM period boundary, so the LEDs never glitch. It is clocked by the system clock and is written only through the SPI frame strobe.

## Interface
Parameters:
- NUM_CH, 3, number of PWM channels. Fixed at 3; the register map below assumes it.
- CTRL_RESET, 8'h00, reset value of the CTRL register.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- address_in  in  8  register address of the last SPI frame.
- data_in  in  8  data byte of the last SPI frame.
- data_ready  in  1  level signal, high while SPI CS is inactive; a frame is complete on its rising edge.
- led_out  out  3  PWM outputs, registered.
- enabled  out  1  high when the FSM is not DISABLED.
- commit_pending  out  1  a COMMIT has been received and not yet applied.
- bad_addr_count  out  8  count of writes to unmapped addresses; saturates at 255.

## Operation
- Write strobe `wr = data_ready & ~dr_q`. The register `dr_q` resets to 1, so the level that is already high out of reset does not produce a write.
- Register map (written on `wr`):
  - 0x00: no-op. This is the frame seen after an idle bus. Not counted as a bad address.
  - 0x01 CTRL: bit0 = enable, bit1 = invert. Other bits are stored and ignored.
  - 0x02 PRESCALE: one PWM tick every PRESCALE+1 clk cycles.
  - 0x03–0x05: DUTY_SH[0..2], the shadow duty registers.
  - 0x06 COMMIT: the data byte is ignored; sets pending.
  - Any other address: bad_addr_count increments, saturating at 255. No other effect.
- PWM generation:
  - An 8-bit counter `cnt` advances by 1 per tick and wraps 255→0.
  - Raw channel value: `cnt < DUTY_ACT[i]`. Duty 0 is always low; duty 255 is high for 255 of every 256 ticks.
  - `led_out[i]` = raw value XOR invert.
- FSM states and transitions:
  - DISABLED:
    - `cnt` = 0, prescaler = 0, `led_out` = {3{invert}}.
    - A COMMIT write copies DUTY_SH→DUTY_ACT on the next edge. commit_pending is never asserted in this state.
    - A CTRL write with enable=1 → RUN.
  - RUN:
    - Counting is active.
    - A COMMIT write → COMMIT_WAIT.
    - A CTRL write with enable=0 → DISABLED.
  - COMMIT_WAIT:
    - Counting is active; commit_pending = 1.
    - On the wrap tick (tick while `cnt`==255): `cnt`←0, DUTY_SH→DUTY_ACT, → RUN.
    - A CTRL write with enable=0 → DISABLED, with DUTY_SH→DUTY_ACT applied on the same edge.
    - Further COMMIT writes have no extra effect.
- Simultaneous events:
  - COMMIT write in RUN on the same cycle as a wrap tick: the wrap is not used. The commit applies at the next wrap, 256 ticks later.
  - DUTY write on the same cycle as a commit apply: DUTY_ACT takes the old DUTY_SH value. The new shadow value waits for the next COMMIT.
  - PRESCALE write: takes effect at the next prescaler reload. The current count is not truncated.
- Reset values:
  - Outputs: led_out = 0, enabled = CTRL_RESET[0], commit_pending = 0, bad_addr_count = 0.
  - Internal: cnt = 0, PRESCALE = 0, DUTY_SH = 0, DUTY_ACT = 0, dr_q = 1.
  - FSM: RUN if CTRL_RESET[0] = 1, else DISABLED.
- Reset asserted mid-operation returns everything to these reset values immediately.

## Timing
- A `wr` in cycle N updates the target register at the clk edge ending cycle N. The new value is visible in N+1.
- `led_out` is registered from `cnt` and DUTY_ACT, so it lags them by one cycle.
- A CTRL enable write lands at edge N. The first tick occurs PRESCALE+1 cycles after that.
- The committed duty appears on `led_out` one cycle after the wrap edge.
- `enabled` and `commit_pending` are registered and reflect the FSM state after each edge.
- Writes arrive at most once per SPI frame (≥16 SCK periods apart). Back-to-back `wr` on consecutive clk cycles must still be handled correctly.

## Test plan
- Reset release with data_ready held high and address/data = 0x00/0x00 → no write occurs; bad_addr_count = 0; led_out = 000.
- Write CTRL=0x01, PRESCALE=0x00, DUTY0=0x40, then COMMIT → commit_pending high until `cnt` wraps, then led_out[0] is high for exactly 64 of every 256 clk cycles.
- While channel 0 runs at 0x40: write DUTY0=0x80 and COMMIT mid-period → led_out[0] finishes the current period at 0x40 and switches to 0x80 from the next period; no runt pulse.
- Issue COMMIT on the exact wrap-tick cycle → the apply is deferred one full period (256 ticks).
- Write CTRL=0x02 (disabled, invert) → led_out = 111 and `cnt` is frozen at 0. COMMIT of DUTY1=0xFF → DUTY_ACT[1] updates on the next edge and commit_pending stays 0.
- Write 300 frames to address 0x7F → bad_addr_count saturates at 255. Assert reset mid-PWM → all outputs return to their reset values on the same cycle.

Source files
------------

// File: rtl/led_pwm_reg_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module   : led_pwm_reg_ctrl_if                                             |
// | Purpose  : SPI frame bus between the SPI slave byte receiver (master side) |
// |            and the LED PWM register controller (slave side).               |
// | Signals  : address_in [7:0] register address of the last SPI frame        |
// |            data_in    [7:0] data byte of the last SPI frame               |
// |            data_ready       high while SPI CS is inactive; a frame is     |
// |                             complete on its rising edge                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface led_pwm_reg_ctrl_if;
   logic [7:0] address_in;
   logic [7:0] data_in;
   logic       data_ready;

   modport master (output address_in, output data_in, output data_ready);
   modport slave  (input  address_in, input  data_in, input  data_ready);
endinterface

`default_nettype wire

// File: rtl/led_pwm_reg_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : led_pwm_reg_ctrl                                                |
// | Purpose  : Decodes SPI (address, data) frames into a small register bank   |
// |            and drives a prescaled 8-bit PWM per LED channel. Duty changes  |
// |            are double-buffered and committed on a PWM period boundary.     |
// | Ports    : clk             system clock, rising edge                       |
// |            reset           asynchronous active-low reset                   |
// |            bus             SPI frame bus (slave modport)                   |
// |            led_out         registered PWM outputs                          |
// |            enabled         FSM is not DISABLED                             |
// |            commit_pending  COMMIT received, not yet applied                |
// |            bad_addr_count  saturating count of unmapped-address writes     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module led_pwm_reg_ctrl #(
   parameter int         NUM_CH     = 3,
   parameter logic [7:0] CTRL_RESET = 8'h00
) (
   input  wire logic              clk,
   input  wire logic              reset,
   led_pwm_reg_ctrl_if.slave      bus,
   output logic [NUM_CH-1:0]      led_out,
   output logic                   enabled,
   output logic                   commit_pending,
   output logic [7:0]             bad_addr_count
);

   localparam logic [7:0] ADDR_CTRL     = 8'h01;
   localparam logic [7:0] ADDR_PRESCALE = 8'h02;
   localparam logic [7:0] ADDR_DUTY0    = 8'h03;
   localparam logic [7:0] ADDR_COMMIT   = 8'h06;

   typedef enum logic [1:0] {
      DISABLED    = 2'd0,
      RUN         = 2'd1,
      COMMIT_WAIT = 2'd2
   } state_t;

   state_t      state;
   logic        dr_q;
   logic [7:0]  ctrl;
   logic [7:0]  prescale;
   logic [7:0]  duty_sh  [NUM_CH];
   logic [7:0]  duty_act [NUM_CH];
   logic [7:0]  cnt;
   logic [7:0]  pre_cnt;
   logic [7:0]  pre_lim;

   logic              wr;
   logic              wr_ctrl;
   logic              wr_prescale;
   logic              wr_commit;
   logic              wr_bad;
   logic              ctrl_on_wr;
   logic              ctrl_off_wr;
   logic              tick;
   logic              wrap;
   logic              apply;
   logic [NUM_CH-1:0] wr_duty;
   logic [NUM_CH-1:0] raw;
   logic              unused_ctrl_bits;

   // dr_q resets high so the idle-high level out of reset is not a write
   assign wr          = bus.data_ready & ~dr_q;
   assign wr_ctrl     = wr && (bus.address_in == ADDR_CTRL);
   assign wr_prescale = wr && (bus.address_in == ADDR_PRESCALE);
   assign wr_commit   = wr && (bus.address_in == ADDR_COMMIT);
   assign wr_bad      = wr && (bus.address_in > ADDR_COMMIT);
   assign ctrl_on_wr  = wr_ctrl &  bus.data_in[0];
   assign ctrl_off_wr = wr_ctrl & ~bus.data_in[0];

   // pre_lim is latched at each reload, so a PRESCALE write never truncates
   // the interval already in progress
   assign tick  = (state != DISABLED) && (pre_cnt == pre_lim);
   assign wrap  = tick && (cnt == 8'hFF);
   assign apply = ((state == DISABLED)    && wr_commit) ||
                  ((state == COMMIT_WAIT) && (ctrl_off_wr || wrap));

   assign unused_ctrl_bits = ^ctrl[7:2];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr_duty[i] = wr && (bus.address_in == (ADDR_DUTY0 + 8'(i)));
      assign raw[i]     = cnt < duty_act[i];
   end

   // Register bank; duty_act samples the pre-edge shadow, so a shadow write
   // coinciding with an apply waits for the next COMMIT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dr_q           <= 1'b1;
         ctrl           <= CTRL_RESET;
         prescale       <= 8'h00;
         bad_addr_count <= 8'h00;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_sh[i]  <= 8'h00;
            duty_act[i] <= 8'h00;
         end
      end else begin
         dr_q <= bus.data_ready;
         if (wr_ctrl)     ctrl     <= bus.data_in;
         if (wr_prescale) prescale <= bus.data_in;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_duty[i]) duty_sh[i]  <= bus.data_in;
            if (apply)      duty_act[i] <= duty_sh[i];
         end
         if (wr_bad && (bad_addr_count != 8'hFF))
            bad_addr_count <= bad_addr_count + 8'd1;
      end
   end

   // Control FSM with PWM counter, prescaler and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= CTRL_RESET[0] ? RUN : DISABLED;
         enabled        <= CTRL_RESET[0];
         commit_pending <= 1'b0;
         cnt            <= 8'h00;
         pre_cnt        <= 8'h00;
         pre_lim        <= 8'h00;
         led_out        <= '0;
      end else begin
         led_out <= (state == DISABLED) ? {NUM_CH{ctrl[1]}}
                                        : (raw ^ {NUM_CH{ctrl[1]}});
         if (state != DISABLED) begin
            if (tick) begin
               pre_cnt <= 8'h00;
               pre_lim <= prescale;
               cnt     <= cnt + 8'd1;
            end else begin
               pre_cnt <= pre_cnt + 8'd1;
            end
         end
         case (state)
            DISABLED: begin
               cnt     <= 8'h00;
               pre_cnt <= 8'h00;
               pre_lim <= prescale;
               if (ctrl_on_wr) begin
                  state   <= RUN;
                  enabled <= 1'b1;
               end
            end
            RUN: begin
               if (ctrl_off_wr) begin
                  state   <= DISABLED;
                  enabled <= 1'b0;
                  cnt     <= 8'h00;
                  pre_cnt <= 8'h00;
               end else if (wr_commit) begin
                  // a wrap on this same cycle is not used: state is still RUN
                  state          <= COMMIT_WAIT;
                  commit_pending <= 1'b1;
               end
            end
            COMMIT_WAIT: begin
               if (ctrl_off_wr) begin
                  state          <= DISABLED;
                  enabled        <= 1'b0;
                  commit_pending <= 1'b0;
                  cnt            <= 8'h00;
                  pre_cnt        <= 8'h00;
               end else if (wrap) begin
                  state          <= RUN;
                  commit_pending <= 1'b0;
               end
            end
            default: begin
               state          <= DISABLED;
               enabled        <= 1'b0;
               commit_pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_reg_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_led_pwm_reg_ctrl                                             |
// | Purpose  : Self-checking bench for led_pwm_reg_ctrl: table of register     |
// |            writes with scoreboarded status expectations, plus hand-written |
// |            PWM period, commit-timing, disable and reset sequences.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_led_pwm_reg_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] led_out;
   logic       enabled;
   logic       commit_pending;
   logic [7:0] bad_addr_count;

   led_pwm_reg_ctrl_if bus_if ();

   led_pwm_reg_ctrl #(.NUM_CH(3), .CTRL_RESET(8'h00)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus_if),
      .led_out        (led_out),
      .enabled        (enabled),
      .commit_pending (commit_pending),
      .bad_addr_count (bad_addr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic       exp_en;
      logic       exp_pend;
      logic [7:0] exp_bad;
   } vec_t;

   typedef struct {
      string      tag;
      logic       en;
      logic       pend;
      logic [7:0] bad;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One SPI frame: CS active for a cycle, then the rising data_ready edge
   task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
      bus_if.address_in = a;
      bus_if.data_in    = d;
      bus_if.data_ready = 1'b0;
      @(negedge clk);
      bus_if.data_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic sb_pop();
      exp_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard underflow", 1, 0);
      end else begin
         e = sb_q.pop_front();
         check({e.tag, " enabled"},        32'(enabled),        32'(e.en));
         check({e.tag, " commit_pending"}, 32'(commit_pending), 32'(e.pend));
         check({e.tag, " bad_addr_count"}, 32'(bad_addr_count), 32'(e.bad));
      end
   endtask

   task automatic wr_expect(input string tag, input logic [7:0] a, input logic [7:0] d,
                            input logic en, input logic pend, input logic [7:0] bad);
      exp_t e;
      e.tag  = tag;
      e.en   = en;
      e.pend = pend;
      e.bad  = bad;
      sb_q.push_back(e);
      wr_frame(a, d);
      sb_pop();
   endtask

   task automatic count_highs(input int n, output int h0, output int h1, output int h2);
      h0 = 0; h1 = 0; h2 = 0;
      repeat (n) begin
         @(negedge clk);
         if (led_out[0]) h0++;
         if (led_out[1]) h1++;
         if (led_out[2]) h2++;
      end
   endtask

   task automatic wait_commit(input string tag, input int max, output int cycles, output int highs0);
      cycles = 0;
      highs0 = 0;
      while (commit_pending === 1'b1 && cycles < max) begin
         @(negedge clk);
         cycles++;
         if (led_out[0]) highs0++;
      end
      check({tag, " commit applied in bound"}, 32'(commit_pending), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, h, h0, h1, h2;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'd0};
      vecs[1] = '{8'h7F, 8'h55, 1'b0, 1'b0, 8'd1};
      vecs[2] = '{8'h07, 8'hAA, 1'b0, 1'b0, 8'd2};
      vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'd3};
      vecs[4] = '{8'h02, 8'h00, 1'b0, 1'b0, 8'd3};
      vecs[5] = '{8'h03, 8'h40, 1'b0, 1'b0, 8'd3};
      vecs[6] = '{8'h01, 8'h01, 1'b1, 1'b0, 8'd3};
      vecs[7] = '{8'h06, 8'h00, 1'b1, 1'b1, 8'd3};

      // Reset with idle bus held high
      reset             = 1'b0;
      bus_if.address_in = 8'h00;
      bus_if.data_in    = 8'h00;
      bus_if.data_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset led_out",        32'(led_out),        0);
      check("reset enabled",        32'(enabled),        0);
      check("reset commit_pending", 32'(commit_pending), 0);
      check("reset bad_addr_count", 32'(bad_addr_count), 0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("post-reset bad_addr_count", 32'(bad_addr_count), 0);
      check("post-reset led_out",        32'(led_out),        0);

      // Register writes: no-op, unmapped addresses, setup, enable, commit
      for (int i = 0; i < 8; i++)
         wr_expect($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data,
                   vecs[i].exp_en, vecs[i].exp_pend, vecs[i].exp_bad);

      // Commit landed at cnt=2: 254 edges to the wrap, old duty 0 meanwhile
      wait_commit("first", 400, cyc, h);
      check("first commit wait cycles", 32'(cyc), 254);
      check("first commit old-duty highs", 32'(h), 0);
      count_highs(256, h0, h1, h2);
      check("duty 0x40 highs ch0", 32'(h0), 64);
      check("duty 0 highs ch1",    32'(h1), 0);
      check("duty 0 highs ch2",    32'(h2), 0);

      // Mid-period change: rest of the period stays at 0x40, then 0x80
      repeat (20) @(negedge clk);
      wr_expect("duty0 0x80", 8'h03, 8'h80, 1'b1, 1'b0, 8'd3);
      wr_expect("mid commit", 8'h06, 8'h00, 1'b1, 1'b1, 8'd3);
      wait_commit("mid", 400, cyc, h);
      check("mid commit wait cycles", 32'(cyc), 232);
      check("mid commit tail highs (old duty)", 32'(h), 40);
      count_highs(256, h0, h1, h2);
      check("duty 0x80 highs ch0", 32'(h0), 128);

      // COMMIT on the exact wrap-tick cycle is deferred a full period
      wr_expect("duty0 0x20", 8'h03, 8'h20, 1'b1, 1'b0, 8'd3);
      repeat (252) @(negedge clk);
      wr_expect("wrap commit", 8'h06, 8'h00, 1'b1, 1'b1, 8'd3);
      wait_commit("wrap", 400, cyc, h);
      check("wrap commit wait cycles", 32'(cyc), 256);
      check("wrap commit deferred-period highs", 32'(h), 128);
      count_highs(256, h0, h1, h2);
      check("duty 0x20 highs ch0", 32'(h0), 32);

      // Disabled with invert: all high, counter frozen; commit applies directly
      wr_expect("ctrl 0x02", 8'h01, 8'h02, 1'b0, 1'b0, 8'd3);
      count_highs(20, h0, h1, h2);
      check("disabled invert highs", 32'(h0 + h1 + h2), 60);
      check("disabled invert led_out", 32'(led_out), 32'h7);
      wr_expect("duty1 0xFF", 8'h04, 8'hFF, 1'b0, 1'b0, 8'd3);
      wr_expect("disabled commit", 8'h06, 8'h00, 1'b0, 1'b0, 8'd3);
      @(negedge clk);
      check("disabled commit_pending stays 0", 32'(commit_pending), 0);
      wr_expect("prescale 3", 8'h02, 8'h03, 1'b0, 1'b0, 8'd3);
      wr_expect("ctrl 0x01", 8'h01, 8'h01, 1'b1, 1'b0, 8'd3);
      count_highs(1024, h0, h1, h2);
      check("prescale 3 duty 0x20 ch0", 32'(h0), 128);
      check("prescale 3 duty 0xFF ch1", 32'(h1), 1020);
      check("prescale 3 duty 0 ch2",    32'(h2), 0);

      // Saturation of the bad-address counter
      for (int i = 0; i < 251; i++) wr_frame(8'h7F, 8'(i));
      check("bad_addr_count 254", 32'(bad_addr_count), 254);
      wr_frame(8'h7F, 8'h00);
      check("bad_addr_count 255", 32'(bad_addr_count), 255);
      for (int i = 0; i < 48; i++) wr_frame(8'h7F, 8'(i));
      check("bad_addr_count saturated", 32'(bad_addr_count), 255);

      // Reset mid-PWM with a commit pending; release with an enable frame held
      wr_expect("pre-reset commit", 8'h06, 8'h00, 1'b1, 1'b1, 8'd255);
      bus_if.address_in = 8'h01;
      bus_if.data_in    = 8'h03;
      bus_if.data_ready = 1'b1;
      reset = 1'b0;
      #1;
      check("async reset led_out",        32'(led_out),        0);
      check("async reset enabled",        32'(enabled),        0);
      check("async reset commit_pending", 32'(commit_pending), 0);
      check("async reset bad_addr_count", 32'(bad_addr_count), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("release no write enabled", 32'(enabled), 0);
      check("release no write led_out", 32'(led_out), 0);

      // CTRL disable in COMMIT_WAIT applies the shadow duty on the same edge
      wr_expect("duty2 0x80",  8'h05, 8'h80, 1'b0, 1'b0, 8'd0);
      wr_expect("prescale 0",  8'h02, 8'h00, 1'b0, 1'b0, 8'd0);
      wr_expect("enable",      8'h01, 8'h01, 1'b1, 1'b0, 8'd0);
      wr_expect("cw commit",   8'h06, 8'h00, 1'b1, 1'b1, 8'd0);
      wr_expect("cw disable",  8'h01, 8'h00, 1'b0, 1'b0, 8'd0);
      wr_expect("re-enable",   8'h01, 8'h01, 1'b1, 1'b0, 8'd0);
      count_highs(256, h0, h1, h2);
      check("disable-apply duty 0x80 ch2", 32'(h2), 128);
      check("disable-apply duty 0 ch0",    32'(h0), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
